// File: rtl/traffic_light_monitor_pkg.sv
// Shared traffic definitions: light codes, monitor phases, fault codes and the
// legal-sample rules used by both the controller and the monitor.
package traffic_light_monitor_pkg;

  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_YELLOW = 2'b01,
    L_GREEN  = 2'b10,
    L_BLINK  = 2'b11
  } light_e;

  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_AGRN = 3'd1,
    M_AYEL = 3'd2,
    M_CLR1 = 3'd3,
    M_BGRN = 3'd4,
    M_BYEL = 3'd5,
    M_CLR2 = 3'd6
  } mon_state_e;

  typedef enum logic [2:0] {
    F_NONE        = 3'd0,
    F_CONFLICT    = 3'd1,
    F_ILLEGAL     = 3'd2,
    F_YELLOW_LEN  = 3'd3,
    F_CLEAR_LEN   = 3'd4,
    F_SHORT_GREEN = 3'd5,
    F_BLINK       = 3'd6
  } fault_e;

  function automatic mon_state_e succ_state(input mon_state_e s);
    case (s)
      M_AGRN:  return M_AYEL;
      M_AYEL:  return M_CLR1;
      M_CLR1:  return M_BGRN;
      M_BGRN:  return M_BYEL;
      M_BYEL:  return M_CLR2;
      M_CLR2:  return M_AGRN;
      default: return M_IDLE;
    endcase
  endfunction

  // Phases only constrain the shape of the sample, not which light carries it.
  function automatic logic legal_sample(input mon_state_e s, input light_e a, input light_e b);
    case (s)
      M_AGRN, M_BGRN: return (a == L_GREEN  && b == L_RED) || (a == L_RED && b == L_GREEN);
      M_AYEL, M_BYEL: return (a == L_YELLOW && b == L_RED) || (a == L_RED && b == L_YELLOW);
      M_CLR1, M_CLR2: return (a == L_RED && b == L_RED);
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light samples in, monitor status out; the controller side is the master.
interface traffic_light_monitor_if;
  logic [1:0] A;
  logic [1:0] B;
  logic       CLR_FAULT;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic [2:0] PHASE;
  logic [7:0] CYCLE_CNT;

  modport master (output A, B, CLR_FAULT, input FAULT, FAULT_CODE, PHASE, CYCLE_CNT);
  modport slave  (input A, B, CLR_FAULT, output FAULT, FAULT_CODE, PHASE, CYCLE_CNT);
endinterface

// File: rtl/traffic_light_monitor_run_counter.sv
// Samples spent in the current monitor phase: loads 1 on a phase change,
// otherwise counts up and sticks at all-ones.
module traffic_light_monitor_run_counter
  import traffic_light_monitor_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  output logic [RUN_W-1:0] run
);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  always_comb begin
    run_d = load ? RUN_W'(1) : sat_inc(run_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) run_q <= '0;
    else     run_q <= run_d;
  end

  assign run = run_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches two car lights for conflicts, illegal sequencing and bad phase
// lengths; latches the first fault and counts completed A-B cycles.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int MIN_GREEN  = 14,
  parameter int YELLOW_LEN = 5,
  parameter int CLEAR_LEN  = 3
) (
  input logic                     CLK,
  input logic                     RST,
  traffic_light_monitor_if.slave  bus
);

  localparam logic [RUN_W-1:0] MIN_GREEN_R  = RUN_W'(MIN_GREEN);
  localparam logic [RUN_W-1:0] YELLOW_LEN_R = RUN_W'(YELLOW_LEN);
  localparam logic [RUN_W-1:0] CLEAR_LEN_R  = RUN_W'(CLEAR_LEN);

  mon_state_e       state_q, state_d;
  logic             fault_q, fault_d;
  fault_e           code_q, code_d;
  logic [7:0]       cycle_q, cycle_d;
  logic             waive_q, waive_d;
  logic [RUN_W-1:0] run_q;

  light_e     a, b;
  mon_state_e nxt_state;
  logic       cur_ok, nxt_ok, conflict, blink, is_green, is_yel, is_clr;
  fault_e     fault_now;

  assign a = light_e'(bus.A);
  assign b = light_e'(bus.B);

  traffic_light_monitor_run_counter run_counter (
    .CLK  (CLK),
    .RST  (RST),
    .load (state_d != state_q),
    .run  (run_q)
  );

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    code_d    = code_q;
    cycle_d   = cycle_q;
    waive_d   = waive_q;
    fault_now = F_NONE;
    nxt_state = succ_state(state_q);
    cur_ok    = legal_sample(state_q, a, b);
    nxt_ok    = legal_sample(nxt_state, a, b);
    conflict  = (a != L_RED) && (b != L_RED);
    blink     = ((a == L_BLINK) || (b == L_BLINK)) && (state_q != M_IDLE);
    is_green  = state_q inside {M_AGRN, M_BGRN};
    is_yel    = state_q inside {M_AYEL, M_BYEL};
    is_clr    = state_q inside {M_CLR1, M_CLR2};

    // Fault sources are tested in priority order; the first hit wins.
    if (conflict) begin
      fault_now = F_CONFLICT;
    end else if (blink) begin
      fault_now = F_BLINK;
    end else if (state_q == M_IDLE) begin
      if (a == L_GREEN && b == L_RED) begin
        state_d = M_AGRN;
        waive_d = 1'b1;
      end else if (a == L_RED && b == L_GREEN) begin
        state_d = M_BGRN;
        waive_d = 1'b1;
      end
    end else if (!cur_ok && !nxt_ok) begin
      fault_now = F_ILLEGAL;
    end else if (cur_ok) begin
      // run_q equal to the exact length means this sample overstays the phase.
      if (is_yel && run_q == YELLOW_LEN_R)     fault_now = F_YELLOW_LEN;
      else if (is_clr && run_q == CLEAR_LEN_R) fault_now = F_CLEAR_LEN;
    end else begin
      if (is_yel && run_q < YELLOW_LEN_R)                     fault_now = F_YELLOW_LEN;
      else if (is_clr && run_q < CLEAR_LEN_R)                 fault_now = F_CLEAR_LEN;
      else if (is_green && !waive_q && run_q < MIN_GREEN_R)   fault_now = F_SHORT_GREEN;
      else begin
        state_d = nxt_state;
        if (is_green)              waive_d = 1'b0;
        if (state_q == M_CLR2)     cycle_d = cycle_q + 8'd1;
      end
    end

    if (bus.CLR_FAULT) begin
      fault_d = 1'b0;
      code_d  = F_NONE;
    end

    // A fault raised in the clearing cycle overrides the clear.
    if (fault_now != F_NONE) begin
      fault_d = 1'b1;
      if (code_d == F_NONE) code_d = fault_now;
      state_d = M_IDLE;
      waive_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= M_IDLE;
      fault_q <= 1'b0;
      code_q  <= F_NONE;
      cycle_q <= 8'd0;
      waive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cycle_q <= cycle_d;
      waive_q <= waive_d;
    end
  end

  assign bus.FAULT      = fault_q;
  assign bus.FAULT_CODE = code_q;
  assign bus.PHASE      = state_q;
  assign bus.CYCLE_CNT  = cycle_q;

endmodule
